// File: rtl/s4ga_reg.sv
// s4ga_reg: serially configured LUT fabric.
//
// A stream of SI_W-bit configuration segments describes N K-input LUTs, one
// after another, and the sequence repeats every frame. Each LUT description is
// K input index fields, one flags segment and the truth-table mask. LUT inputs
// are fetched as soon as their index is complete. The LUT is evaluated on its
// final mask beat, and the result is pushed into a recency history. Later LUTs
// address that history by "how many evaluations ago".
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   si_valid     si carries a segment this cycle (otherwise everything holds)
//   si           configuration segment
//   inputs       fabric inputs, sampled live when an index field completes
//   outputs      registered fabric outputs, updated once per frame
//   frame_done   one-cycle pulse after the last LUT of a frame is evaluated
//   debug_valid  debug carries a fetched LUT input or a pushed LUT value
//   debug        the debug bit (0 when debug_valid is 0)
module s4ga_reg #(
    parameter int N    = 67,
    parameter int K    = 5,
    parameter int I    = 2,
    parameter int O    = 7,
    parameter int SI_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            si_valid,
    input  logic [SI_W-1:0] si,
    input  logic [I-1:0]    inputs,
    output logic [O-1:0]    outputs,
    output logic            frame_done,
    output logic            debug_valid,
    output logic            debug
);
    localparam int IDX_W     = $clog2(2 + I + N);
    localparam int IDX_SEGS  = (IDX_W + SI_W - 1) / SI_W;
    localparam int MASK_SEGS = (2 ** K) / SI_W;
    localparam int IDX_BITS  = IDX_SEGS * SI_W;
    localparam int SEG_MAX   = (MASK_SEGS > IDX_SEGS) ? MASK_SEGS : IDX_SEGS;
    localparam int SEG_W     = (SEG_MAX > 1) ? $clog2(SEG_MAX) : 1;
    localparam int K_W       = $clog2(K);
    localparam int N_W       = $clog2(N);
    localparam int I_W       = (I > 1) ? $clog2(I) : 1;
    localparam int SI_LOG    = $clog2(SI_W);
    localparam int INV_BIT   = (SI_W > 1) ? 1 : 0;
    // Whether the index field can encode values past the last history slot.
    localparam bit HAS_OOR   = (2 + I + N) < (2 ** IDX_BITS);

    localparam logic [IDX_BITS-1:0] IDX_ONE     = IDX_BITS'(1);
    localparam logic [IDX_BITS-1:0] IDX_IN_LO   = IDX_BITS'(2);
    localparam logic [IDX_BITS-1:0] IDX_HIST_LO = IDX_BITS'(2 + I);
    localparam logic [IDX_BITS-1:0] IDX_END     = IDX_BITS'(2 + I + N);

    typedef enum logic [1:0] {
        ST_IDX,
        ST_FLAGS,
        ST_MASK
    } state_t;

    state_t              state_q;
    logic [K_W-1:0]      k_q;
    logic [SEG_W-1:0]    seg_q;
    logic [N_W-1:0]      n_q;
    logic [IDX_BITS-1:0] idx_acc_q;
    logic [K-1:0]        ins_q;
    logic                reg_q;
    logic                inv_q;
    logic                mask_bit_q;
    logic [N-1:0]        hist_q;     // hist_q[m]: value pushed m+1 evaluations ago
    logic [N-1:0]        ff_q;       // per-LUT flip-flop for registered mode
    logic [O-1:0]        outputs_q;
    logic                frame_done_q;
    logic                debug_valid_q;
    logic                debug_q;

    logic [IDX_BITS-1:0] idx_full_d;
    logic [I_W-1:0]      in_sel;
    logic [N_W-1:0]      hist_sel;
    logic                fetch_val_d;
    logic [SEG_W-1:0]    tgt_seg;
    logic                si_bit;
    logic                mask_hit;
    logic                raw_d;
    logic                pushed_d;
    logic [N-1:0]        hist_d;

    always_comb begin
        // Index value including the segment arriving on this beat.
        idx_full_d = (idx_acc_q << SI_W) | IDX_BITS'(si);
        in_sel     = I_W'(idx_full_d - IDX_IN_LO);
        hist_sel   = N_W'(idx_full_d - IDX_HIST_LO);
        if (idx_full_d == '0)
            fetch_val_d = 1'b0;
        else if (idx_full_d == IDX_ONE)
            fetch_val_d = 1'b1;
        else if (idx_full_d < IDX_HIST_LO)
            fetch_val_d = inputs[in_sel];
        else if (!HAS_OOR || idx_full_d < IDX_END)
            fetch_val_d = hist_q[hist_sel];
        else
            fetch_val_d = 1'b0;

        // The mask is big-endian, so mask bit 'ins' lives in segment
        // MASK_SEGS-1-ins/SI_W at position ins%SI_W. Only that one bit is kept.
        tgt_seg = SEG_W'(MASK_SEGS - 1) - SEG_W'(ins_q >> SI_LOG);
        si_bit  = 1'b0;
        for (int b = 0; b < SI_W; b++) begin
            if ((ins_q & K'(SI_W - 1)) == K'(b))
                si_bit = si[b];
        end
        mask_hit = (seg_q == tgt_seg);
        // The wanted bit may arrive on the final mask beat itself.
        raw_d    = (mask_hit ? si_bit : mask_bit_q) ^ inv_q;
        pushed_d = reg_q ? ff_q[n_q] : raw_d;
        hist_d   = {hist_q[N-2:0], pushed_d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDX;
            k_q           <= '0;
            seg_q         <= '0;
            n_q           <= '0;
            idx_acc_q     <= '0;
            ins_q         <= '0;
            reg_q         <= 1'b0;
            inv_q         <= 1'b0;
            mask_bit_q    <= 1'b0;
            hist_q        <= '0;
            ff_q          <= '0;
            outputs_q     <= '0;
            frame_done_q  <= 1'b0;
            debug_valid_q <= 1'b0;
            debug_q       <= 1'b0;
        end else begin
            frame_done_q  <= 1'b0;
            debug_valid_q <= 1'b0;
            debug_q       <= 1'b0;
            if (si_valid) begin
                case (state_q)
                    ST_IDX: begin
                        idx_acc_q <= idx_full_d;
                        if (seg_q == SEG_W'(IDX_SEGS - 1)) begin
                            seg_q         <= '0;
                            ins_q         <= {ins_q[K-2:0], fetch_val_d};
                            debug_valid_q <= 1'b1;
                            debug_q       <= fetch_val_d;
                            if (k_q == K_W'(K - 1)) begin
                                k_q     <= '0;
                                state_q <= ST_FLAGS;
                            end else begin
                                k_q <= k_q + 1'b1;
                            end
                        end else begin
                            seg_q <= seg_q + 1'b1;
                        end
                    end
                    ST_FLAGS: begin
                        reg_q   <= si[0];
                        inv_q   <= (SI_W > 1) && si[INV_BIT];
                        seg_q   <= '0;
                        state_q <= ST_MASK;
                    end
                    ST_MASK: begin
                        if (mask_hit)
                            mask_bit_q <= si_bit;
                        if (seg_q == SEG_W'(MASK_SEGS - 1)) begin
                            hist_q        <= hist_d;
                            debug_valid_q <= 1'b1;
                            debug_q       <= pushed_d;
                            if (reg_q)
                                ff_q[n_q] <= raw_d;
                            if (n_q == N_W'(N - 1)) begin
                                n_q          <= '0;
                                // hist_d[j] is the value pushed by LUT N-1-j.
                                outputs_q    <= hist_d[O-1:0];
                                frame_done_q <= 1'b1;
                            end else begin
                                n_q <= n_q + 1'b1;
                            end
                            seg_q   <= '0;
                            state_q <= ST_IDX;
                        end else begin
                            seg_q <= seg_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDX;
                        seg_q   <= '0;
                        k_q     <= '0;
                    end
                endcase
            end
        end
    end

    assign outputs     = outputs_q;
    assign frame_done  = frame_done_q;
    assign debug_valid = debug_valid_q;
    assign debug       = debug_q;

endmodule
